// File: rtl/xge_mac_tx_arb_if.sv
// Requester-side and MAC-side transmit signals of xge_mac_tx_arb.
// slave = arbiter view, master = environment driving requesters and modelling the MAC.
interface xge_mac_tx_arb_if;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned MOD_W  = 3;

   logic              req0_val;
   logic              req0_sop;
   logic              req0_eop;
   logic [DATA_W-1:0] req0_data;
   logic [MOD_W-1:0]  req0_mod;
   logic              req0_rdy;

   logic              req1_val;
   logic              req1_sop;
   logic              req1_eop;
   logic [DATA_W-1:0] req1_data;
   logic [MOD_W-1:0]  req1_mod;
   logic              req1_rdy;

   logic              pkt_tx_full;
   logic              pkt_tx_val;
   logic              pkt_tx_sop;
   logic              pkt_tx_eop;
   logic [DATA_W-1:0] pkt_tx_data;
   logic [MOD_W-1:0]  pkt_tx_mod;

   modport slave (
      input  req0_val, req0_sop, req0_eop, req0_data, req0_mod,
      output req0_rdy,
      input  req1_val, req1_sop, req1_eop, req1_data, req1_mod,
      output req1_rdy,
      input  pkt_tx_full,
      output pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod
   );

   modport master (
      output req0_val, req0_sop, req0_eop, req0_data, req0_mod,
      input  req0_rdy,
      output req1_val, req1_sop, req1_eop, req1_data, req1_mod,
      input  req1_rdy,
      output pkt_tx_full,
      input  pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_data, pkt_tx_mod
   );
endinterface

// File: rtl/xge_mac_tx_arb.sv
// Packet-granular round-robin arbiter sharing the xge_mac pkt_tx interface between two sources.
// Optional per-requester packet counters enabled by XGE_TX_ARB_STATS_EN.
module xge_mac_tx_arb #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_156m25,
   input  logic             reset_156m25_n,
   xge_mac_tx_arb_if.slave  bus,
   output logic             arb_err,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1
);
   localparam int unsigned DATA_W = 64;
   localparam int unsigned MOD_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT0 = 2'd1,
      PKT1 = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               last_grant;
   logic               last_grant_nxt;
   logic               first_word;
   logic               first_word_nxt;

   logic               cand0_c;
   logic               cand1_c;
   logic               rdy0_c;
   logic               rdy1_c;
   logic               acc_c;
   logic               acc_sop_c;
   logic               acc_eop_c;
   logic [DATA_W-1:0]  acc_data_c;
   logic [MOD_W-1:0]   acc_mod_c;
   logic               err_c;

   logic               tx_val;
   logic               tx_sop;
   logic               tx_eop;
   logic [DATA_W-1:0]  tx_data;
   logic [MOD_W-1:0]   tx_mod;

   assign cand0_c = bus.req0_val & bus.req0_sop;
   assign cand1_c = bus.req1_val & bus.req1_sop;

   // Arbitration, ready generation and selection of the word handed to the output stage
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      first_word_nxt = first_word;
      rdy0_c         = 1'b0;
      rdy1_c         = 1'b0;
      acc_c          = 1'b0;
      acc_sop_c      = 1'b0;
      acc_eop_c      = 1'b0;
      acc_data_c     = '0;
      acc_mod_c      = '0;
      err_c          = 1'b0;
      case (state)
         IDLE: begin
            // Non-sop words seen while idle are swallowed and flagged
            rdy0_c = bus.req0_val & ~bus.req0_sop;
            rdy1_c = bus.req1_val & ~bus.req1_sop;
            err_c  = rdy0_c | rdy1_c;
            if (cand0_c && (!cand1_c || last_grant)) begin
               state_nxt      = PKT0;
               first_word_nxt = 1'b1;
            end else if (cand1_c) begin
               state_nxt      = PKT1;
               first_word_nxt = 1'b1;
            end
         end
         PKT0: begin
            rdy0_c = ~bus.pkt_tx_full;
            if (bus.req0_val && rdy0_c) begin
               acc_c          = 1'b1;
               acc_sop_c      = bus.req0_sop;
               acc_eop_c      = bus.req0_eop;
               acc_data_c     = bus.req0_data;
               acc_mod_c      = bus.req0_eop ? bus.req0_mod : '0;
               err_c          = bus.req0_sop & ~first_word;
               first_word_nxt = 1'b0;
               if (bus.req0_eop) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = 1'b0;
               end
            end
         end
         PKT1: begin
            rdy1_c = ~bus.pkt_tx_full;
            if (bus.req1_val && rdy1_c) begin
               acc_c          = 1'b1;
               acc_sop_c      = bus.req1_sop;
               acc_eop_c      = bus.req1_eop;
               acc_data_c     = bus.req1_data;
               acc_mod_c      = bus.req1_eop ? bus.req1_mod : '0;
               err_c          = bus.req1_sop & ~first_word;
               first_word_nxt = 1'b0;
               if (bus.req1_eop) begin
                  state_nxt      = IDLE;
                  last_grant_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is gated by reset so nothing is reported accepted while the block is held in reset
   assign bus.req0_rdy = reset_156m25_n & rdy0_c;
   assign bus.req1_rdy = reset_156m25_n & rdy1_c;

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         first_word <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         first_word <= first_word_nxt;
      end
   end

   // Output stage: one cycle from accept to the MAC; data/mod hold when idle
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         tx_val  <= 1'b0;
         tx_sop  <= 1'b0;
         tx_eop  <= 1'b0;
         tx_data <= '0;
         tx_mod  <= '0;
         arb_err <= 1'b0;
      end else begin
         tx_val  <= acc_c;
         tx_sop  <= acc_sop_c;
         tx_eop  <= acc_eop_c;
         arb_err <= err_c;
         if (acc_c) begin
            tx_data <= acc_data_c;
            tx_mod  <= acc_mod_c;
         end
      end
   end

   assign bus.pkt_tx_val  = tx_val;
   assign bus.pkt_tx_sop  = tx_sop;
   assign bus.pkt_tx_eop  = tx_eop;
   assign bus.pkt_tx_data = tx_data;
   assign bus.pkt_tx_mod  = tx_mod;

`ifdef XGE_TX_ARB_STATS_EN
   // Packets forwarded per requester, wrapping modulo 2^CNT_W
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (acc_c && acc_eop_c && (state == PKT0)) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
         if (acc_c && acc_eop_c && (state == PKT1)) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
   end
`else
   assign pkt_cnt0 = '0;
   assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_xge_mac_tx_arb.sv
// Self-checking bench for xge_mac_tx_arb: per-requester word scoreboard plus directed scenarios.
module tb_xge_mac_tx_arb;
   localparam int unsigned CNT_W = 4;
`ifdef XGE_TX_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      logic [63:0] data;
      logic        fwd;
   } word_t;

   typedef struct packed {
      logic        src;
      logic [31:0] sop_cyc;
      logic [31:0] eop_cyc;
      logic [31:0] len;
   } pkt_rec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             arb_err;
   logic [CNT_W-1:0] pkt_cnt0;
   logic [CNT_W-1:0] pkt_cnt1;

   xge_mac_tx_arb_if bus ();

   xge_mac_tx_arb #(.CNT_W(CNT_W)) dut (
      .clk_156m25     (clk),
      .reset_156m25_n (rst_n),
      .bus            (bus.slave),
      .arb_err        (arb_err),
      .pkt_cnt0       (pkt_cnt0),
      .pkt_cnt1       (pkt_cnt1)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_fail;
   int unsigned cyc;
   word_t       q0[$];
   word_t       q1[$];
   word_t       s0[$];
   word_t       s1[$];
   pkt_rec_t    plog[$];
   bit          prev_acc;
   bit          err_exp;
   bit          full_force;
   bit          in_pkt;
   bit          cur_src;
   bit          obs_rdy1;
   logic [2:0]  last_mod;
   int unsigned gap_pct;
   int unsigned full_pct;
   int unsigned sop_cyc;
   int unsigned plen;
   int unsigned tx_seen;
   int unsigned ncnt0;
   int unsigned ncnt1;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input bit src, input int unsigned len, input logic [2:0] mod_eop);
      word_t w;
      for (int i = 0; i < int'(len); i++) begin
         w.sop  = (i == 0);
         w.eop  = (i == int'(len) - 1);
         w.mod  = w.eop ? mod_eop : 3'($urandom_range(7, 1));
         w.data = {src, 63'({$urandom, $urandom})};
         w.fwd  = 1'b1;
         if (src) begin q1.push_back(w); s1.push_back(w); end
         else     begin q0.push_back(w); s0.push_back(w); end
      end
   endtask

   task automatic drive();
      word_t h0;
      word_t h1;
      h0 = (q0.size() > 0) ? q0[0] : '0;
      h1 = (q1.size() > 0) ? q1[0] : '0;
      bus.req0_val  = (q0.size() > 0) && ($urandom_range(99) >= gap_pct);
      bus.req0_sop  = h0.sop;
      bus.req0_eop  = h0.eop;
      bus.req0_data = h0.data;
      bus.req0_mod  = h0.mod;
      bus.req1_val  = (q1.size() > 0) && ($urandom_range(99) >= gap_pct);
      bus.req1_sop  = h1.sop;
      bus.req1_eop  = h1.eop;
      bus.req1_data = h1.data;
      bus.req1_mod  = h1.mod;
      bus.pkt_tx_full = full_force || ($urandom_range(99) < full_pct);
   endtask

   // One clock: drive, sample at negedge, score, account acceptances
   task automatic cycle();
      word_t w;
      bit    have;
      bit    src;
      bit    acc0;
      bit    acc1;
      drive();
      @(negedge clk);
      check("tx_val", 128'(bus.pkt_tx_val), 128'(prev_acc));
      if (bus.pkt_tx_val) begin
         src  = bus.pkt_tx_data[63];
         have = 1'b0;
         tx_seen++;
         if (src) begin
            check("sb_has1", 128'(s1.size() != 0), 128'(1));
            if (s1.size() != 0) begin w = s1.pop_front(); have = 1'b1; end
         end else begin
            check("sb_has0", 128'(s0.size() != 0), 128'(1));
            if (s0.size() != 0) begin w = s0.pop_front(); have = 1'b1; end
         end
         if (have)
            check("tx_word", 128'({bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod, bus.pkt_tx_data}),
                  128'({w.sop, w.eop, (w.eop ? w.mod : 3'd0), w.data}));
         if (in_pkt && !bus.pkt_tx_sop) check("contig", 128'(src), 128'(cur_src));
         if (bus.pkt_tx_sop) begin
            in_pkt  = 1'b1;
            cur_src = src;
            sop_cyc = cyc;
            plen    = 0;
         end
         plen++;
         if (bus.pkt_tx_eop) begin
            in_pkt   = 1'b0;
            last_mod = bus.pkt_tx_mod;
            plog.push_back('{src, sop_cyc, cyc, plen});
            if (src) ncnt1++; else ncnt0++;
         end
      end else begin
         check("tx_idle_flags", 128'({bus.pkt_tx_sop, bus.pkt_tx_eop}), 128'(0));
      end
      check("arb_err", 128'(arb_err), 128'(err_exp));
      if (bus.pkt_tx_full) check("rdy_full", 128'({bus.req0_rdy, bus.req1_rdy}), 128'(0));
      check("rdy_onehot", 128'(bus.req0_rdy & bus.req1_rdy), 128'(0));
      check("cnt0", 128'(pkt_cnt0), STATS ? 128'(CNT_W'(ncnt0)) : 128'(0));
      check("cnt1", 128'(pkt_cnt1), STATS ? 128'(CNT_W'(ncnt1)) : 128'(0));
      obs_rdy1 = bus.req1_rdy;
      acc0 = bus.req0_val && bus.req0_rdy && (q0.size() > 0);
      acc1 = bus.req1_val && bus.req1_rdy && (q1.size() > 0);
      prev_acc = (acc0 && q0[0].fwd) || (acc1 && q1[0].fwd);
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_drain(input int unsigned bound);
      int unsigned n = 0;
      while ((q0.size() + q1.size() + s0.size() + s1.size()) != 0 && n < bound) begin
         cycle();
         n++;
      end
      cycle();
      check("drain_left", 128'(q0.size() + q1.size() + s0.size() + s1.size()), 128'(0));
   endtask

   task automatic reset_dut();
      #2 rst_n = 1'b0;
      q0.delete(); q1.delete(); s0.delete(); s1.delete(); plog.delete();
      prev_acc   = 1'b0;
      err_exp    = 1'b0;
      full_force = 1'b0;
      in_pkt     = 1'b0;
      ncnt0      = 0;
      ncnt1      = 0;
      bus.req0_val = 1'b0;
      bus.req1_val = 1'b0;
      bus.pkt_tx_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", 128'({bus.pkt_tx_val, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod,
                                bus.pkt_tx_data, arb_err, bus.req0_rdy, bus.req1_rdy,
                                pkt_cnt0, pkt_cnt1}), 128'(0));
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned c0;
      int unsigned t0;
      word_t       ow;
      n_cmp = 0; n_fail = 0; cyc = 0; tx_seen = 0;
      gap_pct = 0; full_pct = 0; last_mod = '0;
      rst_n = 1'b0;
      bus.req0_val = 1'b0; bus.req0_sop = 1'b0; bus.req0_eop = 1'b0; bus.req0_data = '0; bus.req0_mod = '0;
      bus.req1_val = 1'b0; bus.req1_sop = 1'b0; bus.req1_eop = 1'b0; bus.req1_data = '0; bus.req1_mod = '0;
      bus.pkt_tx_full = 1'b0;
      @(posedge clk);
      #1;
      reset_dut();

      // Single requester, 3 words, mod 5 on eop
      c0 = cyc;
      add_pkt(1'b0, 3, 3'd5);
      run_drain(50);
      check("single_pkts", 128'(plog.size()), 128'(1));
      check("single_src", 128'(plog[0].src), 128'(0));
      check("single_sop_lat", 128'(plog[0].sop_cyc), 128'(c0 + 2));
      check("single_len", 128'(plog[0].len), 128'(3));
      check("single_b2b", 128'(plog[0].eop_cyc - plog[0].sop_cyc), 128'(2));
      check("single_mod", 128'(last_mod), 128'(5));

      // Orphan word on req1 while idle
      ow = '0;
      ow.data = {1'b1, 63'h0bad};
      ow.fwd  = 1'b0;
      q1.push_back(ow);
      t0 = tx_seen;
      cycle();
      check("orphan_rdy", 128'(obs_rdy1), 128'(1));
      err_exp = 1'b1;
      cycle();
      err_exp = 1'b0;
      cycle();
      check("orphan_fwd", 128'(tx_seen - t0), 128'(0));

      // Backpressure for 4 cycles mid-packet
      plog.delete();
      add_pkt(1'b0, 6, 3'($urandom_range(7)));
      for (int i = 0; i < 20 && q0.size() > 4; i++) cycle();
      check("bp_pre", 128'(q0.size()), 128'(4));
      full_force = 1'b1;
      cycle();
      t0 = tx_seen;
      repeat (3) cycle();
      full_force = 1'b0;
      cycle();
      check("bp_quiet", 128'(tx_seen - t0), 128'(0));
      run_drain(50);
      check("bp_pkts", 128'(plog.size()), 128'(1));
      check("bp_len", 128'(plog[0].len), 128'(6));

      // Async reset in the middle of a packet
      add_pkt(1'b0, 5, 3'd2);
      repeat (4) cycle();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", 128'({bus.pkt_tx_val, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod,
                               bus.pkt_tx_data, arb_err, bus.req0_rdy, bus.req1_rdy}), 128'(0));
      reset_dut();

      // Contention from reset exit: req0 first, then strict alternation
      add_pkt(1'b0, 2, 3'd1);
      add_pkt(1'b1, 3, 3'd7);
      add_pkt(1'b0, 1, 3'd0);
      add_pkt(1'b1, 2, 3'd4);
      run_drain(100);
      check("cont_pkts", 128'(plog.size()), 128'(4));
      for (int i = 0; i < 4; i++) check("cont_order", 128'(plog[i].src), 128'(i % 2));
      check("cont_gap", 128'(plog[1].sop_cyc - plog[0].eop_cyc), 128'(2));

      // Randomized traffic with valid gaps and MAC backpressure
      plog.delete();
      gap_pct  = 25;
      full_pct = 20;
      for (int k = 0; k < 20; k++)
         add_pkt(1'($urandom_range(1)), $urandom_range(6, 1), 3'($urandom_range(7)));
      run_drain(3000);
      check("rand_pkts", 128'(plog.size()), 128'(20));

      // Counter wrap: 17 packets from req0 with a 4-bit counter
      gap_pct  = 0;
      full_pct = 0;
      reset_dut();
      for (int k = 0; k < 17; k++) add_pkt(1'b0, 1, 3'($urandom_range(7)));
      run_drain(200);
      check("wrap_cnt0", 128'(pkt_cnt0), STATS ? 128'(1) : 128'(0));
      check("wrap_cnt1", 128'(pkt_cnt1), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
